// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_pkg
// Brief  : Shared widths, size encoding and memory-op layout for mem_initiator.
// Rev    : 1.0
// ============================================================================
package mem_pkg;

    localparam int REQ_ADDR_WIDTH = 32;
    localparam int REQ_DATA_WIDTH = 32;
    localparam int MEM_OP_SIZE    = 4 + REQ_ADDR_WIDTH + REQ_DATA_WIDTH;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic [3:0]                byte_en;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] data;
    } mem_op_t;

    // Size 3 is not a legal access width, so it is rejected like a misalignment.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module : mem_lane_align
// Brief  : Combinational byte-lane placement for stores and extraction/extension for loads.
// Rev    : 1.0
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_byte_en_o,
    output logic [31:0] st_data_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [3:0]  w_be_base;
    logic [31:0] w_ld_shift;
    logic        w_ld_sign;

    always_comb begin
        w_be_base = 4'b1111;
        case (st_size_i)
            SIZE_B:  w_be_base = 4'b0001;
            SIZE_H:  w_be_base = 4'b0011;
            default: w_be_base = 4'b1111;
        endcase
    end

    // Lanes pushed past bit 31 fall off; legal aligned requests never do.
    assign st_byte_en_o = w_be_base << st_off_i;
    assign st_data_o    = st_data_i << {st_off_i, 3'b000};

    assign w_ld_shift = ld_word_i >> {ld_off_i, 3'b000};

    always_comb begin
        w_ld_sign = 1'b0;
        ld_data_o = w_ld_shift;
        case (ld_size_i)
            SIZE_B: begin
                w_ld_sign = ~ld_unsigned_i & w_ld_shift[7];
                ld_data_o = {{24{w_ld_sign}}, w_ld_shift[7:0]};
            end
            SIZE_H: begin
                w_ld_sign = ~ld_unsigned_i & w_ld_shift[15];
                ld_data_o = {{16{w_ld_sign}}, w_ld_shift[15:0]};
            end
            default: ld_data_o = w_ld_shift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module : mem_initiator
// Brief  : Single-outstanding load/store requester for the BRAM put/get protocol.
// Rev    : 1.0
// ============================================================================
module mem_initiator
    import mem_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_is_store,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [31:0]            resp_data,
    output logic                   resp_err,
    output logic                   mem_put_valid,
    input  logic                   mem_put_ready,
    output logic [MEM_OP_SIZE-1:0] mem_put_request,
    output logic                   mem_get_valid,
    input  logic                   mem_get_ready,
    input  logic [MEM_OP_SIZE-1:0] mem_get_response
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q;
    mem_op_t     put_op_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        is_store_q;
    logic        put_valid_q;
    logic        get_valid_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_data_q;

    mem_op_t     w_get_op;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;
    logic        w_bad;

    assign w_get_op = mem_get_response;
    assign w_bad    = is_bad_access(req_size, req_addr[1:0]);

    // Store lanes come from the live request (registered at accept);
    // load lanes use the registered request against the returned word.
    mem_lane_align u_lane_align (
        .st_size_i     (req_size),
        .st_off_i      (req_addr[1:0]),
        .st_data_i     (req_data),
        .st_byte_en_o  (w_st_be),
        .st_data_o     (w_st_data),
        .ld_size_i     (size_q),
        .ld_off_i      (put_op_q.addr[1:0]),
        .ld_unsigned_i (unsigned_q),
        .ld_word_i     (w_get_op.data),
        .ld_data_o     (w_ld_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            put_op_q     <= '0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            is_store_q   <= 1'b0;
            put_valid_q  <= 1'b0;
            get_valid_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        size_q           <= req_size;
                        unsigned_q       <= req_unsigned;
                        is_store_q       <= req_is_store;
                        put_op_q.addr    <= req_addr;
                        put_op_q.byte_en <= req_is_store ? w_st_be : 4'd0;
                        put_op_q.data    <= req_is_store ? w_st_data : 32'd0;
                        if (w_bad) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= 32'd0;
                            state_q      <= S_RESP;
                        end else begin
                            put_valid_q  <= 1'b1;
                            state_q      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_put_ready) begin
                        put_valid_q <= 1'b0;
                        get_valid_q <= 1'b1;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_get_ready) begin
                        get_valid_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= is_store_q ? 32'd0 : w_ld_data;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= 32'd0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready       = (state_q == S_IDLE) && !RST;
    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_data       = resp_data_q;
    assign mem_put_valid   = put_valid_q;
    assign mem_put_request = put_op_q;
    assign mem_get_valid   = get_valid_q;

    // The responder must echo the address it was given; it has no functional effect here.
    a_get_addr_match: assert property (@(posedge CLK) disable iff (RST)
        (state_q == S_WAIT && mem_get_ready) |->
            ((w_get_op.addr == put_op_q.addr) && !$isunknown(w_get_op)));

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_initiator
// Brief  : Directed scoreboard bench for mem_initiator with a stallable memory responder.
// Rev    : 1.0
// ============================================================================
module tb_mem_initiator;
    import mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_data = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_put_valid;
    logic        mem_put_ready = 1'b0;
    logic [67:0] mem_put_request;
    logic        mem_get_valid;
    logic        mem_get_ready = 1'b0;
    logic [67:0] mem_get_response = 68'd0;

    mem_initiator dut (
        .CLK              (CLK),
        .RST              (RST),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_err         (resp_err),
        .mem_put_valid    (mem_put_valid),
        .mem_put_ready    (mem_put_ready),
        .mem_put_request  (mem_put_request),
        .mem_get_valid    (mem_get_valid),
        .mem_get_ready    (mem_get_ready),
        .mem_get_response (mem_get_response)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [67:0] exp_put_q[$];
    logic [67:0] pend_q[$];
    int unsigned mem[int unsigned];

    int n_cmp = 0;
    int n_bad = 0;
    int put_stall = 0, get_stall = 0, resp_stall = 0;
    int put_wait = 0, get_wait = 0, resp_wait = 0;
    int n_put = 0, n_get = 0;
    logic [67:0] put_hold;
    logic [32:0] resp_hold;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder and response monitor, all sampled on the falling edge.
    always @(negedge CLK) begin
        if (RST) begin
            mem_put_ready = 1'b0;
            mem_get_ready = 1'b0;
            resp_ready    = 1'b0;
            put_wait = 0; get_wait = 0; resp_wait = 0;
        end else begin
            if (mem_put_valid || mem_get_valid)
                check("req_ready_busy", {67'd0, req_ready}, 68'd0);

            if (mem_put_valid) begin
                if (put_wait > 0) check("put_stable", mem_put_request, put_hold);
                put_hold = mem_put_request;
                if (put_wait >= put_stall) begin
                    logic [67:0] op;
                    int unsigned idx, word;
                    mem_put_ready = 1'b1;
                    n_put++;
                    op = mem_put_request;
                    if (exp_put_q.size() == 0) begin
                        check("put_unexpected", op, 68'd0);
                    end else begin
                        check("put_req", op, exp_put_q.pop_front());
                    end
                    idx  = op[63:32] >> 2;
                    word = mem.exists(idx) ? mem[idx] : 0;
                    for (int i = 0; i < 4; i++)
                        if (op[64+i]) word[8*i +: 8] = op[8*i +: 8];
                    mem[idx] = word;
                    pend_q.push_back({op[67:64], op[63:32], word});
                end else begin
                    mem_put_ready = 1'b0;
                end
                put_wait++;
            end else begin
                mem_put_ready = 1'b0;
                put_wait = 0;
            end

            if (mem_get_valid) begin
                if (get_wait >= get_stall && pend_q.size() > 0) begin
                    mem_get_ready    = 1'b1;
                    mem_get_response = pend_q.pop_front();
                    n_get++;
                end else begin
                    mem_get_ready = 1'b0;
                end
                get_wait++;
            end else begin
                mem_get_ready = 1'b0;
                get_wait = 0;
            end

            if (resp_valid) begin
                check("req_ready_busy", {67'd0, req_ready}, 68'd0);
                if (resp_wait == 0) begin
                    if (exp_q.size() == 0) check("resp_unexpected", {35'd0, resp_err, resp_data}, 68'd0);
                    else check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                end else begin
                    check("resp_stable", {35'd0, resp_err, resp_data}, {35'd0, resp_hold});
                end
                resp_hold = {resp_err, resp_data};
                if (resp_wait >= resp_stall) begin
                    resp_ready = 1'b1;
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("resp_data", {36'd0, resp_data}, {36'd0, e.data});
                        check("resp_err", {67'd0, resp_err}, {67'd0, e.err});
                    end
                end else begin
                    resp_ready = 1'b0;
                end
                resp_wait++;
            end else begin
                resp_ready = 1'b0;
                resp_wait = 0;
            end
        end
    end

    task automatic send(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [67:0] exp_put, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        int k;
        @(negedge CLK);
        req_is_store = st; req_size = sz; req_unsigned = uns; req_addr = a; req_data = d;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge CLK); k++; end
        if (!req_ready) check("accept_timeout", 68'd0, 68'd1);
        e.data = exp_data;
        e.err  = exp_err;
        e.lat  = exp_err ? 1 : 3 + put_stall + get_stall;
        e.acc  = cyc;
        exp_q.push_back(e);
        if (!exp_err) exp_put_q.push_back(exp_put);
        @(negedge CLK);
        req_valid = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 100) begin @(negedge CLK); k++; end
        if (exp_q.size() > 0) begin
            check("resp_timeout", 68'd0, 68'd1);
            exp_q.delete();
        end
    endtask

    initial begin
        int p0, g0, k;
        repeat (3) @(negedge CLK);
        check("rst_req_ready", {67'd0, req_ready}, 68'd0);
        check("rst_valids", {65'd0, resp_valid, mem_put_valid, mem_get_valid}, 68'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_req_ready", {67'd0, req_ready}, 68'd1);

        send(1, SIZE_W, 0, 32'h100, 32'hDEADBEEF, {4'hF, 32'h100, 32'hDEADBEEF}, 32'h0, 0);
        mem[32'h40] = 32'h80FF1234;
        send(0, SIZE_B, 0, 32'h103, 32'h0, {4'h0, 32'h103, 32'h0}, 32'hFFFFFF80, 0);
        send(0, SIZE_B, 1, 32'h103, 32'h0, {4'h0, 32'h103, 32'h0}, 32'h00000080, 0);
        send(1, SIZE_H, 0, 32'h202, 32'h0000ABCD, {4'hC, 32'h202, 32'hABCD0000}, 32'h0, 0);
        send(0, SIZE_H, 1, 32'h202, 32'h0, {4'h0, 32'h202, 32'h0}, 32'h0000ABCD, 0);
        send(0, SIZE_H, 0, 32'h202, 32'h0, {4'h0, 32'h202, 32'h0}, 32'hFFFFABCD, 0);
        send(1, SIZE_B, 0, 32'h301, 32'h12345678, {4'h2, 32'h301, 32'h34567800}, 32'h0, 0);
        send(0, SIZE_B, 0, 32'h301, 32'h0, {4'h0, 32'h301, 32'h0}, 32'h00000078, 0);

        p0 = n_put;
        send(0, SIZE_W, 0, 32'h101, 32'h0, 68'd0, 32'h0, 1);
        send(0, 2'd3,   0, 32'h100, 32'h0, 68'd0, 32'h0, 1);
        send(1, SIZE_H, 0, 32'h203, 32'h5555, 68'd0, 32'h0, 1);
        check("err_no_put", n_put - p0, 0);

        put_stall = 5; get_stall = 3; resp_stall = 4;
        p0 = n_put; g0 = n_get;
        send(0, SIZE_W, 0, 32'h100, 32'h0, {4'h0, 32'h100, 32'h0}, 32'h80FF1234, 0);
        repeat (3) @(negedge CLK);
        check("bp_one_put", n_put - p0, 1);
        check("bp_one_get", n_get - g0, 1);
        put_stall = 0; resp_stall = 0;

        // Abandon a load while it waits on the memory response.
        get_stall = 20;
        @(negedge CLK);
        req_is_store = 0; req_size = SIZE_W; req_unsigned = 0; req_addr = 32'h100;
        req_valid = 1'b1;
        exp_put_q.push_back({4'h0, 32'h100, 32'h0});
        @(negedge CLK);
        req_valid = 1'b0;
        k = 0;
        while (!mem_get_valid && k < 20) begin @(negedge CLK); k++; end
        check("reach_wait", {67'd0, mem_get_valid}, 68'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_valids", {65'd0, resp_valid, mem_put_valid, mem_get_valid}, 68'd0);
        check("midrst_req_ready", {67'd0, req_ready}, 68'd0);
        pend_q.delete();
        exp_put_q.delete();
        get_stall = 0;
        RST = 1'b0;
        @(negedge CLK);
        check("postrst_req_ready", {67'd0, req_ready}, 68'd1);
        send(0, SIZE_W, 0, 32'h100, 32'h0, {4'h0, 32'h100, 32'h0}, 32'h80FF1234, 0);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
